// File: rtl/omok_game_ctrl.sv
// Omok (five-in-a-row) game controller: cursor movement, stone placement with
// undo history, and a one-neighbour-per-cycle win scan around the last stone.
`timescale 1ns/1ps
module omok_game_ctrl #(
  parameter int MAP_N   = 10,
  parameter int WIN_LEN = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [2:0]               key_code,
  output logic [7:0]               cursor_pos,
  output logic [MAP_N*MAP_N-1:0]   board_state,
  output logic [MAP_N*MAP_N-1:0]   turn_map,
  output logic                     turn,
  output logic [6:0]               move_count,
  output logic                     busy,
  output logic                     game_over,
  output logic                     winner_valid,
  output logic                     winner
);

  localparam int N2    = MAP_N * MAP_N;
  localparam int IDX_W = $clog2(N2);
  localparam int RC_W  = $clog2(MAP_N);
  localparam int PW    = RC_W + 2;
  localparam int RUN_W = $clog2(WIN_LEN);

  localparam logic [2:0] K_UP    = 3'd0;
  localparam logic [2:0] K_LEFT  = 3'd1;
  localparam logic [2:0] K_PUT   = 3'd2;
  localparam logic [2:0] K_RIGHT = 3'd3;
  localparam logic [2:0] K_UNDO  = 3'd4;
  localparam logic [2:0] K_DOWN  = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, OVER = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [RC_W-1:0]        cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [RC_W-1:0]        chk_row_q, chk_row_d, chk_col_q, chk_col_d;
  logic [N2-1:0]          board_q, board_d, tmap_q, tmap_d;
  logic                   turn_q, turn_d, go_q, go_d, wv_q, wv_d, win_q, win_d;
  logic [6:0]             mc_q, mc_d;
  logic [1:0]             axis_q, axis_d;
  logic                   dir_q, dir_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic signed [PW-1:0]   pr_q, pr_d, pc_q, pc_d;
  logic [2*RC_W-1:0]      stack_q [N2];
  logic                   push_en, do_undo;
  logic [RC_W-1:0]        pop_row, pop_col;
  logic [IDX_W-1:0]       cur_idx, pop_idx, nb_idx;
  int                     dr, dc, nr, nc;
  logic                   nb_in, nb_match;

  // The stack pointer is move_count itself: one entry per stone on the board.
  assign {pop_row, pop_col} = stack_q[IDX_W'(mc_q - 7'd1)];
  assign cur_idx = IDX_W'(cur_row_q * MAP_N + cur_col_q);
  assign pop_idx = IDX_W'(pop_row * MAP_N + pop_col);

  // Next probe cell along the current axis/direction, bounds checked on row and column.
  always_comb begin
    dr = 0;
    dc = 0;
    case (axis_q)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    if (dir_q) begin
      dr = -dr;
      dc = -dc;
    end
    nr       = int'(pr_q) + dr;
    nc       = int'(pc_q) + dc;
    nb_in    = (nr >= 0) && (nr < MAP_N) && (nc >= 0) && (nc < MAP_N);
    nb_idx   = IDX_W'(nr * MAP_N + nc);
    nb_match = nb_in && board_q[nb_idx] && (tmap_q[nb_idx] == turn_q);
  end

  always_comb begin
    state_d   = state_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    chk_row_d = chk_row_q;
    chk_col_d = chk_col_q;
    board_d   = board_q;
    tmap_d    = tmap_q;
    turn_d    = turn_q;
    go_d      = go_q;
    wv_d      = wv_q;
    win_d     = win_q;
    mc_d      = mc_q;
    axis_d    = axis_q;
    dir_d     = dir_q;
    run_d     = run_q;
    pr_d      = pr_q;
    pc_d      = pc_q;
    push_en   = 1'b0;
    do_undo   = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_valid) begin
          case (key_code)
            K_UP:    if (cur_row_q != '0) cur_row_d = cur_row_q - 1'b1;
            K_DOWN:  if (cur_row_q != RC_W'(MAP_N - 1)) cur_row_d = cur_row_q + 1'b1;
            K_LEFT:  if (cur_col_q != '0) cur_col_d = cur_col_q - 1'b1;
            K_RIGHT: if (cur_col_q != RC_W'(MAP_N - 1)) cur_col_d = cur_col_q + 1'b1;
            K_PUT: begin
              if (!board_q[cur_idx]) begin
                board_d[cur_idx] = 1'b1;
                tmap_d[cur_idx]  = turn_q;
                push_en          = 1'b1;
                mc_d             = mc_q + 7'd1;
                chk_row_d        = cur_row_q;
                chk_col_d        = cur_col_q;
                axis_d           = 2'd0;
                dir_d            = 1'b0;
                run_d            = '0;
                pr_d             = PW'(cur_row_q);
                pc_d             = PW'(cur_col_q);
                state_d          = CHECK;
              end
            end
            K_UNDO:  do_undo = 1'b1;
            default: ;
          endcase
        end
      end
      CHECK: begin
        // A match that completes WIN_LEN ends the scan at once, so the step cap never binds.
        if (nb_match && (int'(run_q) + 2 >= WIN_LEN)) begin
          go_d    = 1'b1;
          wv_d    = 1'b1;
          win_d   = turn_q;
          state_d = OVER;
        end else if (nb_match) begin
          run_d = run_q + 1'b1;
          pr_d  = PW'(nr);
          pc_d  = PW'(nc);
        end else begin
          pr_d = PW'(chk_row_q);
          pc_d = PW'(chk_col_q);
          if (!dir_q) begin
            dir_d = 1'b1;
          end else if (axis_q != 2'd3) begin
            axis_d = axis_q + 2'd1;
            dir_d  = 1'b0;
            run_d  = '0;
          end else if (mc_q == 7'(N2)) begin
            go_d    = 1'b1;
            state_d = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = IDLE;
          end
        end
      end
      OVER: begin
        if (key_valid && key_code == K_UNDO) do_undo = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (do_undo && mc_q != 7'd0) begin
      board_d[pop_idx] = 1'b0;
      tmap_d[pop_idx]  = 1'b0;
      mc_d             = mc_q - 7'd1;
      turn_d           = tmap_q[pop_idx];
      cur_row_d        = pop_row;
      cur_col_d        = pop_col;
      go_d             = 1'b0;
      wv_d             = 1'b0;
      win_d            = 1'b0;
      state_d          = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_row_q <= RC_W'(MAP_N / 2 - 1);
      cur_col_q <= RC_W'(MAP_N / 2 - 1);
      chk_row_q <= '0;
      chk_col_q <= '0;
      board_q   <= '0;
      tmap_q    <= '0;
      turn_q    <= 1'b0;
      go_q      <= 1'b0;
      wv_q      <= 1'b0;
      win_q     <= 1'b0;
      mc_q      <= '0;
      axis_q    <= '0;
      dir_q     <= 1'b0;
      run_q     <= '0;
      pr_q      <= '0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      chk_row_q <= chk_row_d;
      chk_col_q <= chk_col_d;
      board_q   <= board_d;
      tmap_q    <= tmap_d;
      turn_q    <= turn_d;
      go_q      <= go_d;
      wv_q      <= wv_d;
      win_q     <= win_d;
      mc_q      <= mc_d;
      axis_q    <= axis_d;
      dir_q     <= dir_d;
      run_q     <= run_d;
      pr_q      <= pr_d;
      pc_q      <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !rst) stack_q[IDX_W'(mc_q)] <= {cur_row_q, cur_col_q};
  end

  assign cursor_pos   = 8'(cur_row_q * MAP_N + cur_col_q);
  assign board_state  = board_q;
  assign turn_map     = tmap_q;
  assign turn         = turn_q;
  assign move_count   = mc_q;
  assign busy         = (state_q == CHECK);
  assign game_over    = go_q;
  assign winner_valid = wv_q;
  assign winner       = win_q;

endmodule
